// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: buffers one vector and one scalar result and grants the
// shared decode-stage register write port to one of them per cycle.
module reg_wb_arbiter #(
    parameter int SCA_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_valid,
    output logic        v_ready,
    input  logic [2:0]  v_dir,
    input  logic [31:0] v_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_dir,
    input  logic [7:0]  s_data,
    output logic        reg_wrv,
    output logic        reg_wrs,
    output logic [3:0]  i_dir_wr,
    output logic [31:0] data_wrv,
    output logic [7:0]  data_wrs,
    output logic [7:0]  pend_v,
    output logic [15:0] pend_s,
    output logic        idle
);

    logic        v_full_q, v_full_d;
    logic [2:0]  v_dir_q, v_dir_d;
    logic [31:0] v_data_q, v_data_d;
    logic        s_full_q, s_full_d;
    logic [3:0]  s_dir_q, s_dir_d;
    logic [7:0]  s_data_q, s_data_d;
    logic        last_q, last_d;

    logic        reg_wrv_q, reg_wrv_d;
    logic        reg_wrs_q, reg_wrs_d;
    logic [3:0]  i_dir_wr_q, i_dir_wr_d;
    logic [31:0] data_wrv_q, data_wrv_d;
    logic [7:0]  data_wrs_q, data_wrs_d;

    logic        grant_v, grant_s;
    logic        v_acc, s_acc;

    function automatic logic [7:0] dec_v(input logic [2:0] dir);
        dec_v = 8'd1 << dir;
    endfunction

    function automatic logic [15:0] dec_s(input logic [3:0] dir);
        dec_s = 16'd1 << dir;
    endfunction

    // Grant depends only on holding state, so ready never combinationally
    // depends on the incoming valid.
    always_comb begin
        grant_v = 1'b0;
        grant_s = 1'b0;
        if (v_full_q && s_full_q) begin
            if (SCA_PRIO != 0) begin
                grant_s = 1'b1;
            end else if (last_q) begin
                grant_v = 1'b1;
            end else begin
                grant_s = 1'b1;
            end
        end else begin
            grant_v = v_full_q;
            grant_s = s_full_q;
        end
    end

    assign v_ready = !v_full_q || grant_v;
    assign s_ready = !s_full_q || grant_s;
    assign v_acc   = v_valid && v_ready;
    assign s_acc   = s_valid && s_ready;

    // A granted entry may be refilled at the same edge it drains.
    always_comb begin
        v_full_d = v_full_q;
        v_dir_d  = v_dir_q;
        v_data_d = v_data_q;
        if (v_acc) begin
            v_full_d = 1'b1;
            v_dir_d  = v_dir;
            v_data_d = v_data;
        end else if (grant_v) begin
            v_full_d = 1'b0;
        end

        s_full_d = s_full_q;
        s_dir_d  = s_dir;
        s_data_d = s_data;
        if (!s_acc) begin
            s_dir_d  = s_dir_q;
            s_data_d = s_data_q;
        end
        if (s_acc) begin
            s_full_d = 1'b1;
        end else if (grant_s) begin
            s_full_d = 1'b0;
        end

        last_d = last_q;
        if (grant_v) begin
            last_d = 1'b0;
        end else if (grant_s) begin
            last_d = 1'b1;
        end
    end

    // Address and data hold their last values when nothing is granted.
    always_comb begin
        reg_wrv_d  = 1'b0;
        reg_wrs_d  = 1'b0;
        i_dir_wr_d = i_dir_wr_q;
        data_wrv_d = data_wrv_q;
        data_wrs_d = data_wrs_q;
        if (grant_v) begin
            reg_wrv_d  = 1'b1;
            i_dir_wr_d = {1'b0, v_dir_q};
            data_wrv_d = v_data_q;
        end else if (grant_s) begin
            reg_wrs_d  = 1'b1;
            i_dir_wr_d = s_dir_q;
            data_wrs_d = s_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_full_q   <= 1'b0;
            s_full_q   <= 1'b0;
            last_q     <= 1'b1;
            reg_wrv_q  <= 1'b0;
            reg_wrs_q  <= 1'b0;
            i_dir_wr_q <= 4'd0;
            data_wrv_q <= 32'd0;
            data_wrs_q <= 8'd0;
        end else begin
            v_full_q   <= v_full_d;
            s_full_q   <= s_full_d;
            last_q     <= last_d;
            reg_wrv_q  <= reg_wrv_d;
            reg_wrs_q  <= reg_wrs_d;
            i_dir_wr_q <= i_dir_wr_d;
            data_wrv_q <= data_wrv_d;
            data_wrs_q <= data_wrs_d;
        end
    end

    // Held payload is qualified by the full flags, so it needs no reset.
    always_ff @(posedge clk) begin
        v_dir_q  <= v_dir_d;
        v_data_q <= v_data_d;
        s_dir_q  <= s_dir_d;
        s_data_q <= s_data_d;
    end

    assign reg_wrv  = reg_wrv_q;
    assign reg_wrs  = reg_wrs_q;
    assign i_dir_wr = i_dir_wr_q;
    assign data_wrv = data_wrv_q;
    assign data_wrs = data_wrs_q;

    assign pend_v = (v_full_q ? dec_v(v_dir_q) : 8'd0)
                  | (reg_wrv_q ? dec_v(i_dir_wr_q[2:0]) : 8'd0);
    assign pend_s = (s_full_q ? dec_s(s_dir_q) : 16'd0)
                  | (reg_wrs_q ? dec_s(i_dir_wr_q) : 16'd0);
    assign idle   = !v_full_q && !s_full_q && !reg_wrv_q && !reg_wrs_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: round-robin and scalar-priority instances share
// stimulus and are checked against a queue-level model plus literal points.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_valid = 1'b0;
    logic [2:0]  v_dir = 3'd0;
    logic [31:0] v_data = 32'd0;
    logic        s_valid = 1'b0;
    logic [3:0]  s_dir = 4'd0;
    logic [7:0]  s_data = 8'd0;

    logic        v_ready [2];
    logic        s_ready [2];
    logic        reg_wrv [2];
    logic        reg_wrs [2];
    logic [3:0]  i_dir_wr [2];
    logic [31:0] data_wrv [2];
    logic [7:0]  data_wrs [2];
    logic [7:0]  pend_v [2];
    logic [15:0] pend_s [2];
    logic        idle [2];

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.SCA_PRIO(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .v_valid(v_valid), .v_ready(v_ready[0]), .v_dir(v_dir), .v_data(v_data),
        .s_valid(s_valid), .s_ready(s_ready[0]), .s_dir(s_dir), .s_data(s_data),
        .reg_wrv(reg_wrv[0]), .reg_wrs(reg_wrs[0]), .i_dir_wr(i_dir_wr[0]),
        .data_wrv(data_wrv[0]), .data_wrs(data_wrs[0]),
        .pend_v(pend_v[0]), .pend_s(pend_s[0]), .idle(idle[0])
    );

    reg_wb_arbiter #(.SCA_PRIO(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .v_valid(v_valid), .v_ready(v_ready[1]), .v_dir(v_dir), .v_data(v_data),
        .s_valid(s_valid), .s_ready(s_ready[1]), .s_dir(s_dir), .s_data(s_data),
        .reg_wrv(reg_wrv[1]), .reg_wrs(reg_wrs[1]), .i_dir_wr(i_dir_wr[1]),
        .data_wrv(data_wrv[1]), .data_wrs(data_wrs[1]),
        .pend_v(pend_v[1]), .pend_s(pend_s[1]), .idle(idle[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each requester owns a one-slot mailbox; the write port is a
    // "what was written last cycle" record.
    bit          model_ok = 0;
    bit          mb_v [2];
    int          mb_v_dir [2];
    logic [31:0] mb_v_data [2];
    bit          mb_s [2];
    int          mb_s_dir [2];
    logic [7:0]  mb_s_data [2];
    bit          scalar_went_last [2];
    bit          wr_v [2];
    bit          wr_s [2];
    int          wr_addr [2];
    logic [31:0] wr_vdata [2];
    logic [7:0]  wr_sdata [2];

    // Returns 1 = vector wins, 2 = scalar wins, 0 = nobody waiting.
    function automatic int winner(int k);
        if (mb_v[k] && mb_s[k]) begin
            if (k == 1) return 2;
            return scalar_went_last[k] ? 1 : 2;
        end
        if (mb_v[k]) return 1;
        if (mb_s[k]) return 2;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int  w;
            bit  take_v, take_s;
            w = winner(k);
            if (!rst_n) begin
                mb_v[k] = 0; mb_s[k] = 0; scalar_went_last[k] = 1;
                wr_v[k] = 0; wr_s[k] = 0; wr_addr[k] = 0;
                wr_vdata[k] = 0; wr_sdata[k] = 0;
            end else begin
                take_v = v_valid && (!mb_v[k] || w == 1);
                take_s = s_valid && (!mb_s[k] || w == 2);
                wr_v[k] = (w == 1);
                wr_s[k] = (w == 2);
                if (w == 1) begin
                    wr_addr[k] = mb_v_dir[k]; wr_vdata[k] = mb_v_data[k];
                    mb_v[k] = 0; scalar_went_last[k] = 0;
                end
                if (w == 2) begin
                    wr_addr[k] = mb_s_dir[k]; wr_sdata[k] = mb_s_data[k];
                    mb_s[k] = 0; scalar_went_last[k] = 1;
                end
                if (take_v) begin
                    mb_v[k] = 1; mb_v_dir[k] = int'(v_dir); mb_v_data[k] = v_data;
                end
                if (take_s) begin
                    mb_s[k] = 1; mb_s_dir[k] = int'(s_dir); mb_s_data[k] = s_data;
                end
            end
        end
        model_ok = 1;
    end

    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                logic [7:0]  pv;
                logic [15:0] ps;
                int w;
                w = winner(k);
                pv = 0;
                ps = 0;
                for (int r = 0; r < 8; r++)
                    pv[r] = (mb_v[k] && mb_v_dir[k] == r) || (wr_v[k] && wr_addr[k] == r);
                for (int r = 0; r < 16; r++)
                    ps[r] = (mb_s[k] && mb_s_dir[k] == r) || (wr_s[k] && wr_addr[k] == r);
                chk($sformatf("m%0d.reg_wrv", k), 32'(reg_wrv[k]), 32'(wr_v[k]));
                chk($sformatf("m%0d.reg_wrs", k), 32'(reg_wrs[k]), 32'(wr_s[k]));
                chk($sformatf("m%0d.i_dir_wr", k), 32'(i_dir_wr[k]), 32'(wr_addr[k]));
                chk($sformatf("m%0d.data_wrv", k), data_wrv[k], wr_vdata[k]);
                chk($sformatf("m%0d.data_wrs", k), 32'(data_wrs[k]), 32'(wr_sdata[k]));
                chk($sformatf("m%0d.v_ready", k), 32'(v_ready[k]), 32'(!mb_v[k] || w == 1));
                chk($sformatf("m%0d.s_ready", k), 32'(s_ready[k]), 32'(!mb_s[k] || w == 2));
                chk($sformatf("m%0d.pend_v", k), 32'(pend_v[k]), 32'(pv));
                chk($sformatf("m%0d.pend_s", k), 32'(pend_s[k]), 32'(ps));
                chk($sformatf("m%0d.idle", k), 32'(idle[k]),
                    32'(!mb_v[k] && !mb_s[k] && !wr_v[k] && !wr_s[k]));
                chk($sformatf("m%0d.one_strobe", k), 32'(reg_wrv[k] && reg_wrs[k]), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v_valid = 1'b0; s_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int nv, ns;
        do_reset();
        step();

        // Single vector write: dir 5, 0xDEADBEEF
        chk("rst.idle", 32'(idle[0]), 32'd1);
        chk("rst.v_ready", 32'(v_ready[0]), 32'd1);
        v_valid = 1; v_dir = 3'd5; v_data = 32'hDEADBEEF;
        step();
        v_valid = 0;
        chk("t1.pend_held", 32'(pend_v[0]), 32'h20);
        chk("t1.no_strobe_yet", 32'(reg_wrv[0]), 32'd0);
        step();
        chk("t1.reg_wrv", 32'(reg_wrv[0]), 32'd1);
        chk("t1.i_dir_wr", 32'(i_dir_wr[0]), 32'h5);
        chk("t1.data_wrv", data_wrv[0], 32'hDEADBEEF);
        chk("t1.pend_strobe", 32'(pend_v[0]), 32'h20);
        step();
        chk("t1.strobe_done", 32'(reg_wrv[0]), 32'd0);
        chk("t1.pend_clear", 32'(pend_v[0]), 32'h0);
        chk("t1.idle", 32'(idle[0]), 32'd1);

        // Simultaneous V dir 2 and S dir 9 after fresh reset
        do_reset();
        v_valid = 1; v_dir = 3'd2; v_data = 32'h0000_1234;
        s_valid = 1; s_dir = 4'd9; s_data = 8'h5A;
        step();
        v_valid = 0; s_valid = 0;
        chk("t2.s_ready_low", 32'(s_ready[0]), 32'd0);
        chk("t2.v_ready_high", 32'(v_ready[0]), 32'd1);
        chk("t2.prio_v_ready_low", 32'(v_ready[1]), 32'd0);
        step();
        chk("t2.v_first", 32'(reg_wrv[0]), 32'd1);
        chk("t2.v_dir", 32'(i_dir_wr[0]), 32'h2);
        chk("t2.s_ready_back", 32'(s_ready[0]), 32'd1);
        chk("t2.prio_s_first", 32'(reg_wrs[1]), 32'd1);
        step();
        chk("t2.s_second", 32'(reg_wrs[0]), 32'd1);
        chk("t2.s_dir", 32'(i_dir_wr[0]), 32'h9);
        chk("t2.s_data", 32'(data_wrs[0]), 32'h5A);
        step();

        // Both streaming for 8 write cycles
        do_reset();
        v_valid = 1; s_valid = 1;
        v_dir = 3'd1; v_data = 32'h1000_0000;
        s_dir = 4'd3; s_data = 8'h40;
        step();
        nv = 0; ns = 0;
        for (int j = 0; j < 8; j++) begin
            v_dir = 3'(j); v_data = 32'h1000_0001 + 32'(j);
            s_dir = 4'(j + 8); s_data = 8'h41 + 8'(j);
            step();
            chk("t3.alt_v", 32'(reg_wrv[0]), 32'(j % 2 == 0));
            chk("t3.alt_s", 32'(reg_wrs[0]), 32'(j % 2 == 1));
            chk("t3.prio_no_v", 32'(reg_wrv[1]), 32'd0);
            chk("t3.prio_v_ready", 32'(v_ready[1]), 32'd0);
            nv += int'(reg_wrv[0]);
            ns += int'(reg_wrs[0]);
        end
        chk("t3.total_writes", 32'(nv + ns), 32'd8);
        chk("t3.v_writes", 32'(nv), 32'd4);
        s_valid = 0;
        v_valid = 0;
        for (int j = 0; j < 4; j++) step();
        chk("t4.prio_drained", 32'(idle[1]), 32'd1);
        chk("t3.drained", 32'(idle[0]), 32'd1);

        // Vector stream alone, dirs 0..7
        for (int i = 0; i < 8; i++) begin
            v_valid = 1; v_dir = 3'(i); v_data = 32'hA000_0000 | 32'(i);
            chk("t5.v_ready", 32'(v_ready[0]), 32'd1);
            step();
            if (i > 0) begin
                chk("t5.pulse", 32'(reg_wrv[0]), 32'd1);
                chk("t5.dir", 32'(i_dir_wr[0]), 32'(i - 1));
            end
        end
        v_valid = 0;
        step();
        chk("t5.last_pulse", 32'(reg_wrv[0]), 32'd1);
        chk("t5.last_dir", 32'(i_dir_wr[0]), 32'd7);
        step();

        // Reset with both holding registers full
        v_valid = 1; v_dir = 3'd6; s_valid = 1; s_dir = 4'd12;
        step();
        v_valid = 1; s_valid = 1;
        step();
        rst_n = 0; v_valid = 0; s_valid = 0;
        step();
        chk("t6.no_v_strobe", 32'(reg_wrv[0]), 32'd0);
        chk("t6.no_s_strobe", 32'(reg_wrs[0]), 32'd0);
        chk("t6.pend_v", 32'(pend_v[0]), 32'd0);
        chk("t6.pend_s", 32'(pend_s[0]), 32'd0);
        chk("t6.idle", 32'(idle[0]), 32'd1);
        chk("t6.idle_prio", 32'(idle[1]), 32'd1);
        rst_n = 1;
        step();
        chk("t6.still_idle", 32'(idle[0]), 32'd1);
        chk("t6.ready", 32'(v_ready[0] && s_ready[0]), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
